sdram_arb: RTL
==============

Name: sdram_arb

Overview:
- Round-robin arbiter sharing the single SDRAM controller between N_PORTS requesters (CPU fetch, CPU data, display, DMA).
- Sits between the requesters and the controller's sdram_wr_req/sdram_rd_req/ack handshake.
- Drives a port-select code so the datapath mux routes the winner's address and data.
- Tracks each transaction to completion, reports completion per port, and flags stalled transactions via a timeout.

Parameters:
N_PORTS, 4, number of requesters (2..4)
ID_W, 2, width of the port-select code
TIMEOUT, 1024, max cycles from controller request to ack falling edge before abort

Ports:
clk_100m  in  1  system clock, 100 MHz
rst  in  1  asynchronous reset, active-high
port_req  in  N_PORTS  per-port request level, held until port_done
port_rw_n  in  N_PORTS  per-port direction: 0 read, 1 write; sampled at grant
port_grant  out  N_PORTS  one-hot grant, high for the whole transaction
port_done  out  N_PORTS  one-cycle completion pulse to the granted port
sel  out  ID_W  index of the granted port, for the datapath mux
sdram_init_done  in  1  controller initialisation complete
sdram_wr_req  out  1  write request to controller
sdram_rd_req  out  1  read request to controller
sdram_wr_ack  in  1  controller write ack, level, multi-cycle
sdram_rd_ack  in  1  controller read ack, level, multi-cycle
sys_rw_n  out  1  registered direction of the current transaction
busy  out  1  high in any state other than IDLE
timeout_err  out  1  sticky error flag, cleared only by rst
err_port  out  ID_W  port id of the most recent timed-out transaction

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; rr_ptr=0.
  - All outputs 0: port_grant, port_done, sel, sdram_wr_req, sdram_rd_req, sys_rw_n, busy, timeout_err, err_port.
  - Reset mid-transaction abandons it with no done pulse.
- FSM states: IDLE, REQ, ACK, DONE.
- IDLE:
  - If sdram_init_done=1 and any port_req is set, pick the winner by round robin.
    - Search starts at rr_ptr and wraps at N_PORTS-1 -> 0.
    - Register port_grant (one-hot), sel, and sys_rw_n = port_rw_n[winner].
    - Go to REQ.
  - Latency: port_req sampled at edge t; grant and controller request visible after edge t+1.
  - If sdram_init_done=0, no grant regardless of requests.
- REQ:
  - Assert sdram_wr_req if sys_rw_n=1, else sdram_rd_req. Exactly one is asserted.
  - When the matching ack is 1: drop the request and go to ACK.
  - The non-matching ack is ignored.
- ACK:
  - Wait for the matching ack to return to 0, then go to DONE.
  - A rd_ack level lasting several cycles counts as one transaction.
- DONE (one cycle):
  - port_done[sel]=1 for exactly this cycle.
  - Clear port_grant; rr_ptr = sel+1 (wraps to 0 at N_PORTS).
  - Return to IDLE. The next grant is possible on the following edge, so there is one idle cycle between transactions.
- Timeout:
  - A 16-bit counter clears on entry to REQ and increments in REQ/ACK.
  - When it reaches TIMEOUT-1: set timeout_err=1 and err_port=sel, drop all requests, clear grant, go to IDLE.
  - No port_done pulse; rr_ptr still advances past the failed port.
- Boundary rules:
  - A requester dropping port_req while granted has no effect; the transaction completes normally.
  - Acks arriving in IDLE or DONE are ignored.
  - If the only requester is the one just served, it wins again after the idle cycle.
  - port_rw_n changes after grant are ignored.
  - With N_PORTS < 4, unused index values never appear on sel.

Optional Feature:
SDRAM_ARB_FIXED_PRIO_EN:
- Defined: fixed priority, lowest index wins; rr_ptr is held at 0 and never updated.
- Undefined: round robin as above.
- All other timing, handshake and timeout behaviour is identical in both builds.

Test Plan:
- Reset released with sdram_init_done=0 and port_req=4'b1111 held 100 cycles -> port_grant=0 and busy=0 throughout; init_done=1 -> port_grant=4'b0001 two edges later.
- Port 2 write (port_rw_n[2]=1); controller model asserts wr_ack at 3 cycles for 2 cycles -> sdram_wr_req high until the first ack cycle, sel=2, sys_rw_n=1, one port_done[2] pulse after ack falls.
- port_req=4'b1111 continuously, each access acked -> grant order 0,1,2,3,0,...; with SDRAM_ARB_FIXED_PRIO_EN defined -> port 0 on every grant.
- Port 1 read, rd_ack high 8 cycles -> exactly one port_done[1] pulse and no second sdram_rd_req.
- TIMEOUT=16, port 3 read never acked -> timeout_err=1 and err_port=3 after 16 cycles, no port_done, next grant goes to port 0.
- rst asserted while in ACK -> all outputs 0 asynchronously; after release a pending port_req[1] is granted afresh.

Source files
------------

// File: rtl/sdram_arb.sv
// sdram_arb: arbiter sharing one SDRAM controller between N_PORTS requesters.
//
// Picks a winner (round robin, or fixed priority when SDRAM_ARB_FIXED_PRIO_EN is
// defined), runs the controller's level request/ack handshake to completion,
// pulses port_done to the winner and aborts transactions that stall.
//
// Ports:
//   clk_100m         system clock
//   rst              asynchronous reset, active-high
//   port_req         per-port request level, held until port_done
//   port_rw_n        per-port direction (0 read, 1 write), sampled at grant
//   port_grant       one-hot grant, high for the whole transaction
//   port_done        one-cycle completion pulse to the granted port
//   sel              index of the granted port for the datapath mux
//   sdram_init_done  controller initialisation complete
//   sdram_wr_req     write request to controller
//   sdram_rd_req     read request to controller
//   sdram_wr_ack     controller write ack (level, multi-cycle)
//   sdram_rd_ack     controller read ack (level, multi-cycle)
//   sys_rw_n         registered direction of the current transaction
//   busy             high whenever the arbiter is not idle
//   timeout_err      sticky stall flag, cleared only by rst
//   err_port         port id of the most recent timed-out transaction
//
// Build option: define SDRAM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module sdram_arb #(
    parameter int unsigned N_PORTS = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic               clk_100m,
    input  logic               rst,
    input  logic [N_PORTS-1:0] port_req,
    input  logic [N_PORTS-1:0] port_rw_n,
    output logic [N_PORTS-1:0] port_grant,
    output logic [N_PORTS-1:0] port_done,
    output logic [ID_W-1:0]    sel,
    input  logic               sdram_init_done,
    output logic               sdram_wr_req,
    output logic               sdram_rd_req,
    input  logic               sdram_wr_ack,
    input  logic               sdram_rd_ack,
    output logic               sys_rw_n,
    output logic               busy,
    output logic               timeout_err,
    output logic [ID_W-1:0]    err_port
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    logic [1:0]         state_q, state_d;
    logic [N_PORTS-1:0] grant_q, grant_d;
    logic [ID_W-1:0]    sel_q, sel_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    err_port_q, err_port_d;
    logic               sys_rw_n_q, sys_rw_n_d;
    logic               timeout_err_q, timeout_err_d;
    logic [15:0]        cnt_q, cnt_d;

    logic               win_found;
    logic [ID_W-1:0]    win_idx;
    logic [ID_W:0]      cand;
    logic [ID_W-1:0]    ptr_next;
    logic               ack_match;

    // Only the ack matching the registered direction is ever looked at.
    assign ack_match = sys_rw_n_q ? sdram_wr_ack : sdram_rd_ack;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    // Pointer pinned at 0: the search below degenerates to lowest-index-wins.
    assign ptr_next = '0;
`else
    assign ptr_next = (sel_q == ID_W'(N_PORTS - 1)) ? '0 : sel_q + ID_W'(1);
`endif

    // Search from rr_ptr upwards, wrapping at N_PORTS-1; first requester wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < int'(N_PORTS); i++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W + 1)'(i);
            if (cand >= (ID_W + 1)'(N_PORTS)) begin
                cand = cand - (ID_W + 1)'(N_PORTS);
            end
            if (!win_found && port_req[cand[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        sel_d         = sel_q;
        rr_ptr_d      = rr_ptr_q;
        sys_rw_n_d    = sys_rw_n_q;
        timeout_err_d = timeout_err_q;
        err_port_d    = err_port_q;
        cnt_d         = cnt_q;
        case (state_q)
            IDLE: begin
                if (sdram_init_done && win_found) begin
                    state_d    = REQ;
                    grant_d    = {{(N_PORTS - 1){1'b0}}, 1'b1} << win_idx;
                    sel_d      = win_idx;
                    sys_rw_n_d = port_rw_n[win_idx];
                    cnt_d      = '0;
                end
            end
            REQ, ACK: begin
                cnt_d = cnt_q + 16'd1;
                // A stall wins over a same-cycle ack event.
                if (cnt_q == CNT_LAST) begin
                    state_d       = IDLE;
                    grant_d       = '0;
                    timeout_err_d = 1'b1;
                    err_port_d    = sel_q;
                    rr_ptr_d      = ptr_next;
                end else if (state_q == REQ && ack_match) begin
                    state_d = ACK;
                end else if (state_q == ACK && !ack_match) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d  = IDLE;
                grant_d  = '0;
                rr_ptr_d = ptr_next;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            sel_q         <= '0;
            rr_ptr_q      <= '0;
            sys_rw_n_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            err_port_q    <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            sel_q         <= sel_d;
            rr_ptr_q      <= rr_ptr_d;
            sys_rw_n_q    <= sys_rw_n_d;
            timeout_err_q <= timeout_err_d;
            err_port_q    <= err_port_d;
            cnt_q         <= cnt_d;
        end
    end

    assign port_grant   = grant_q;
    assign port_done    = (state_q == DONE) ? grant_q : '0;
    assign sel          = sel_q;
    assign sys_rw_n     = sys_rw_n_q;
    assign busy         = (state_q != IDLE);
    assign sdram_wr_req = (state_q == REQ) && sys_rw_n_q;
    assign sdram_rd_req = (state_q == REQ) && !sys_rw_n_q;
    assign timeout_err  = timeout_err_q;
    assign err_port     = err_port_q;

endmodule
